// File: rtl/ddc_cfg_sequencer.sv
// ddc_cfg_sequencer: per-lane DDS phase table with a commit-driven loader.
// On commit each lane is written in turn over a shared cfg bus (one-hot
// cfg_valid). An optional settle gap and a single broadcast resync pulse
// follow the load. One commit arriving mid-sequence is held as pending.
module ddc_cfg_sequencer #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned PH_W   = 20,
    parameter int unsigned SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [PH_W-1:0]   wr_pinc,
    input  logic [PH_W-1:0]   wr_poff,
    input  logic              commit,
    input  logic              commit_resync,
    output logic              busy,
    output logic              done,
    output logic              wr_err,
    output logic [PH_W-1:0]   cfg_pinc,
    output logic [PH_W-1:0]   cfg_poff,
    output logic [N_CH-1:0]   cfg_valid,
    output logic              cfg_resync
);

    localparam int unsigned SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RESYNC,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CH_W-1:0]   r_k, w_k_nxt;
    logic [SC_W-1:0]   r_sc, w_sc_nxt;
    logic              r_rs, w_rs_nxt;
    logic              r_pend, w_pend_nxt;
    logic              r_pend_rs, w_pend_rs_nxt;

    logic [PH_W-1:0]   r_tab_pinc [N_CH];
    logic [PH_W-1:0]   r_tab_poff [N_CH];

    logic              r_busy, r_done, r_wr_err, r_resync;
    logic [N_CH-1:0]   r_valid;
    logic [PH_W-1:0]   r_pinc, r_poff;

    logic              w_ch_ok, w_wr_ok, w_wr_rej;
    logic              w_byp;
    logic [PH_W-1:0]   w_rd_pinc, w_rd_poff;
    logic [N_CH-1:0]   w_valid_nxt;

    assign w_ch_ok  = 32'(wr_ch) < N_CH;
    assign w_wr_ok  = wr_en && (r_state == S_IDLE) && w_ch_ok;
    assign w_wr_rej = wr_en && !w_wr_ok;

    // Outputs are registered from the next state, so the lane read for the
    // first load must bypass a write landing in the same commit cycle.
    assign w_byp     = w_wr_ok && (wr_ch == w_k_nxt);
    assign w_rd_pinc = w_byp ? wr_pinc : r_tab_pinc[w_k_nxt];
    assign w_rd_poff = w_byp ? wr_poff : r_tab_poff[w_k_nxt];
    assign w_valid_nxt = (w_state_nxt == S_LOAD) ? (N_CH'(1) << w_k_nxt) : '0;

    // Next-state logic: sequencing, lane/settle counters, pending commit merge
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_sc_nxt      = r_sc;
        w_rs_nxt      = r_rs;
        w_pend_nxt    = r_pend;
        w_pend_rs_nxt = r_pend_rs;

        if (commit && (r_state != S_IDLE)) begin
            w_pend_nxt    = 1'b1;
            w_pend_rs_nxt = r_pend_rs | commit_resync;
        end

        case (r_state)
            S_IDLE: begin
                if (commit) begin
                    w_state_nxt = S_LOAD;
                    w_k_nxt     = '0;
                    w_rs_nxt    = commit_resync;
                end
            end
            S_LOAD: begin
                if (r_k == CH_W'(N_CH - 1)) begin
                    w_state_nxt = r_rs ? S_SETTLE : S_DONE;
                    w_sc_nxt    = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_sc == SC_W'(SETTLE - 1)) begin
                    w_state_nxt = S_RESYNC;
                end else begin
                    w_sc_nxt = r_sc + 1'b1;
                end
            end
            S_RESYNC: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // A commit seen in this very cycle already folded into the
                // pending flags above, so it restarts the load here too.
                if (w_pend_nxt) begin
                    w_state_nxt   = S_LOAD;
                    w_k_nxt       = '0;
                    w_rs_nxt      = w_pend_rs_nxt;
                    w_pend_nxt    = 1'b0;
                    w_pend_rs_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_sc      <= '0;
            r_rs      <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_rs <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_sc      <= w_sc_nxt;
            r_rs      <= w_rs_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_rs <= w_pend_rs_nxt;
        end
    end

    // Phase table: writable only while idle and for an in-range channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_tab_pinc[i] <= '0;
                r_tab_poff[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_tab_pinc[wr_ch] <= wr_pinc;
            r_tab_poff[wr_ch] <= wr_poff;
        end
    end

    // Registered outputs; the cfg data bus holds its value between loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
            r_resync <= 1'b0;
            r_valid  <= '0;
            r_pinc   <= '0;
            r_poff   <= '0;
        end else begin
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
            r_resync <= (w_state_nxt == S_RESYNC);
            r_wr_err <= w_wr_rej;
            r_valid  <= w_valid_nxt;
            if (w_state_nxt == S_LOAD) begin
                r_pinc <= w_rd_pinc;
                r_poff <= w_rd_poff;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign wr_err     = r_wr_err;
    assign cfg_resync = r_resync;
    assign cfg_valid  = r_valid;
    assign cfg_pinc   = r_pinc;
    assign cfg_poff   = r_poff;

endmodule

// File: tb/tb_ddc_cfg_sequencer.sv
// Scoreboard bench for ddc_cfg_sequencer (N_CH=4, CH_W=3 so channel 4..7
// can be addressed). Stimulus pushes expected events tagged with the cycle
// they must appear in; a negedge monitor pops and compares them.
module tb_ddc_cfg_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 4;

    logic        clk, rst_n, wr_en, commit, commit_resync;
    logic [2:0]  wr_ch;
    logic [19:0] wr_pinc, wr_poff;
    logic        busy, done, wr_err, cfg_resync;
    logic [19:0] cfg_pinc, cfg_poff;
    logic [3:0]  cfg_valid;

    ddc_cfg_sequencer #(.N_CH(4), .CH_W(3), .PH_W(20), .SETTLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pinc(wr_pinc), .wr_poff(wr_poff), .commit(commit),
        .commit_resync(commit_resync), .busy(busy), .done(done),
        .wr_err(wr_err), .cfg_pinc(cfg_pinc), .cfg_poff(cfg_poff),
        .cfg_valid(cfg_valid), .cfg_resync(cfg_resync)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  v;
        logic [19:0] pinc;
        logic [19:0] poff;
    } ld_t;

    ld_t         q_load[$];
    int unsigned q_rs[$], q_done[$], q_err[$], q_fall[$];

    logic [19:0] m_pinc [4];
    logic [19:0] m_poff [4];

    int unsigned cyc = 0;
    int unsigned n_pass = 0, n_total = 0;
    logic        prev_busy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: pop expected events whenever the DUT presents one
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (cfg_valid != 4'b0) begin
                if (q_load.size() == 0) chk("load_unexpected", 64'(cfg_valid), 64'd0);
                else begin
                    ld_t e;
                    e = q_load.pop_front();
                    chk("load_cycle", 64'(cyc), 64'(e.cyc));
                    chk("load_valid", 64'(cfg_valid), 64'(e.v));
                    chk("load_pinc", 64'(cfg_pinc), 64'(e.pinc));
                    chk("load_poff", 64'(cfg_poff), 64'(e.poff));
                end
            end
            if (cfg_valid != 4'b0 || cfg_resync)
                chk("onehot_excl", {62'd0, $onehot0(cfg_valid), (cfg_valid != 4'b0) && cfg_resync}, 64'd2);
            if (cfg_resync) begin
                if (q_rs.size() == 0) chk("resync_unexpected", 64'd1, 64'd0);
                else chk("resync_cycle", 64'(cyc), 64'(q_rs.pop_front()));
            end
            if (done) begin
                if (q_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else chk("done_cycle", 64'(cyc), 64'(q_done.pop_front()));
            end
            if (wr_err) begin
                if (q_err.size() == 0) chk("wr_err_unexpected", 64'd1, 64'd0);
                else chk("wr_err_cycle", 64'(cyc), 64'(q_err.pop_front()));
            end
            if (prev_busy && !busy) begin
                if (q_fall.size() == 0) chk("busy_fall_unexpected", 64'd1, 64'd0);
                else chk("busy_fall_cycle", 64'(cyc), 64'(q_fall.pop_front()));
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Push expected loads (and resync/done) for a sequence committed at t0
    task automatic expect_seq(input int unsigned t0, input bit rs, output int unsigned dcyc);
        for (int k = 0; k < 4; k++) begin
            ld_t e;
            e.cyc  = t0 + 1 + k;
            e.v    = 4'(1 << k);
            e.pinc = m_pinc[k];
            e.poff = m_poff[k];
            q_load.push_back(e);
        end
        if (rs) begin
            q_rs.push_back(t0 + N + S + 1);
            dcyc = t0 + N + S + 2;
        end else begin
            dcyc = t0 + N + 1;
        end
        q_done.push_back(dcyc);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [19:0] p, input logic [19:0] o, input bit ok);
        wr_en = 1'b1; wr_ch = ch; wr_pinc = p; wr_poff = o;
        if (ok) begin
            m_pinc[ch[1:0]] = p;
            m_poff[ch[1:0]] = o;
        end else begin
            q_err.push_back(cyc + 1);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit(input bit rs);
        commit = 1'b1; commit_resync = rs;
        tick();
        commit = 1'b0; commit_resync = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            #1;
            if (!busy && q_load.size() == 0 && q_rs.size() == 0 && q_done.size() == 0
                && q_err.size() == 0 && q_fall.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] outs();
        return {16'd0, busy, done, wr_err, cfg_resync, cfg_valid, cfg_pinc, cfg_poff};
    endfunction

    initial begin
        int unsigned t, d1, d2;
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_pinc = '0; wr_poff = '0;
        commit = 1'b0; commit_resync = 1'b0;
        for (int k = 0; k < 4; k++) begin m_pinc[k] = '0; m_poff[k] = '0; end
        repeat (3) tick();
        #1 chk("reset_outputs", outs(), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: load four lanes with resync
        for (int k = 0; k < 4; k++) wr(3'(k), 20'(32'h100 * (k + 1)), 20'h0, 1'b1);
        t = cyc;
        expect_seq(t, 1'b1, d1);
        q_fall.push_back(t + 11);
        pulse_commit(1'b1);
        wait_idle();

        // 2: distinct offsets, no resync
        for (int k = 0; k < 4; k++) wr(3'(k), 20'(32'h100 * (k + 1)), 20'(32'h0A000 + k), 1'b1);
        t = cyc;
        expect_seq(t, 1'b0, d1);
        q_fall.push_back(t + 6);
        pulse_commit(1'b0);
        wait_idle();

        // 3: write while busy and out-of-range channels are rejected
        t = cyc;
        expect_seq(t, 1'b0, d1);
        q_fall.push_back(t + 6);
        pulse_commit(1'b0);
        wr(3'd1, 20'hFFFFF, 20'hFFFFF, 1'b0);
        wait_idle();
        wr(3'd4, 20'h12345, 20'h54321, 1'b0);
        wr(3'd7, 20'h0F0F0, 20'h0F0F0, 1'b0);
        t = cyc;
        expect_seq(t, 1'b0, d1);
        q_fall.push_back(t + 6);
        pulse_commit(1'b0);
        wait_idle();

        // 4: pending commits merge into exactly one follow-on sequence
        t = cyc;
        expect_seq(t, 1'b0, d1);
        expect_seq(d1, 1'b1, d2);
        q_fall.push_back(d2 + 1);
        pulse_commit(1'b0);
        tick();
        pulse_commit(1'b1);
        pulse_commit(1'b0);
        wait_idle();

        // 5: write and commit in the same idle cycle
        t = cyc;
        m_pinc[2] = 20'hABCDE; m_poff[2] = 20'h54321;
        expect_seq(t, 1'b0, d1);
        q_fall.push_back(t + 6);
        wr_en = 1'b1; wr_ch = 3'd2; wr_pinc = 20'hABCDE; wr_poff = 20'h54321;
        commit = 1'b1; commit_resync = 1'b0;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        wait_idle();

        // 6: reset mid-load aborts and clears the table
        t = cyc;
        for (int k = 0; k < 2; k++) begin
            ld_t e;
            e.cyc = t + 1 + k; e.v = 4'(1 << k); e.pinc = m_pinc[k]; e.poff = m_poff[k];
            q_load.push_back(e);
        end
        pulse_commit(1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", outs(), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin m_pinc[k] = '0; m_poff[k] = '0; end
        tick();
        chk("after_reset_queue", 64'(q_load.size()), 64'd0);
        t = cyc;
        expect_seq(t, 1'b0, d1);
        q_fall.push_back(t + 6);
        pulse_commit(1'b0);
        wait_idle();
        repeat (3) tick();

        chk("left_load", 64'(q_load.size()), 64'd0);
        chk("left_done", 64'(q_done.size() + q_rs.size() + q_err.size() + q_fall.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
